// File: rtl/bimodal_btb_predictor.sv
// Fetch-stage bimodal predictor: direct-mapped tagged BTB, untagged 2-bit PHT, MIPS branch/jump decode.
// Optional BP_TRACE_EN macro adds a simulation-only per-cycle trace; behaviour is identical without it.
module bimodal_btb_predictor #(
  parameter int BTB_IDX_BITS = 6,
  parameter int PHT_IDX_BITS = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        FLUSH,
  input  logic [31:0] Instr_input,
  input  logic [31:0] Instr_addr_input,
  input  logic [31:0] Branch_instr,
  input  logic [31:0] Branch_addr,
  input  logic        Branch_resolved,
  input  logic [31:0] Branch_resolved_addr,
  output logic        Taken,
  output logic [31:0] Taken_addr
);
  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int PHT_N = 1 << PHT_IDX_BITS;
  localparam int TAG_W = 32 - BTB_IDX_BITS - 2;

  function automatic logic dec_branch(input logic [31:0] ins);
    logic [5:0] op;
    logic [4:0] rt;
    op = ins[31:26];
    rt = ins[20:16];
    case (op)
      6'd4, 6'd5, 6'd6, 6'd7: return 1'b1;
      6'd1:                   return rt inside {5'd0, 5'd1, 5'd16, 5'd17};
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic dec_jump(input logic [31:0] ins);
    logic [5:0] op;
    logic [5:0] funct;
    op    = ins[31:26];
    funct = ins[5:0];
    return (op == 6'd2) || (op == 6'd3) ||
           ((op == 6'd0) && ((funct == 6'd8) || (funct == 6'd9)));
  endfunction

  logic             btb_valid_q  [BTB_N];
  logic [TAG_W-1:0] btb_tag_q    [BTB_N];
  logic [31:0]      btb_target_q [BTB_N];
  logic [1:0]       pht_q        [PHT_N];

  logic        taken_q, taken_d;
  logic [31:0] taken_addr_q, taken_addr_d;

  logic [BTB_IDX_BITS-1:0] f_btb_idx, m_btb_idx;
  logic [PHT_IDX_BITS-1:0] f_pht_idx, m_pht_idx;
  logic [TAG_W-1:0]        f_tag, m_tag;
  logic                    f_is_branch, f_is_jump, f_hit, f_pred;
  logic                    m_is_branch, m_is_jump, m_ctl;
  logic [1:0]              pht_cur, pht_d;

  // Word-aligned PCs: the byte-offset bits never take part in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{Instr_addr_input[1:0], Branch_addr[1:0]};

  assign f_btb_idx = Instr_addr_input[BTB_IDX_BITS+1:2];
  assign f_pht_idx = Instr_addr_input[PHT_IDX_BITS+1:2];
  assign f_tag     = Instr_addr_input[31:BTB_IDX_BITS+2];
  assign m_btb_idx = Branch_addr[BTB_IDX_BITS+1:2];
  assign m_pht_idx = Branch_addr[PHT_IDX_BITS+1:2];
  assign m_tag     = Branch_addr[31:BTB_IDX_BITS+2];

  assign f_is_branch = dec_branch(Instr_input);
  assign f_is_jump   = dec_jump(Instr_input);
  assign m_is_branch = dec_branch(Branch_instr);
  assign m_is_jump   = dec_jump(Branch_instr);
  assign m_ctl       = m_is_branch | m_is_jump;
  assign pht_cur     = pht_q[m_pht_idx];

  // Lookup reads the registered tables, so a same-cycle update to the same entry is not visible.
  always_comb begin
    f_hit        = (f_is_branch | f_is_jump) & btb_valid_q[f_btb_idx] &
                   (btb_tag_q[f_btb_idx] == f_tag);
    f_pred       = f_hit & (f_is_jump | pht_q[f_pht_idx][1]);
    taken_d      = 1'b0;
    taken_addr_d = 32'h0;
    if (!FLUSH && f_pred) begin
      taken_d      = 1'b1;
      taken_addr_d = btb_target_q[f_btb_idx];
    end
  end

  always_comb begin
    pht_d = pht_cur;
    if (Branch_resolved) begin
      if (pht_cur != 2'd3) pht_d = pht_cur + 2'd1;
    end else begin
      if (pht_cur != 2'd0) pht_d = pht_cur - 2'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      taken_q      <= 1'b0;
      taken_addr_q <= 32'h0;
    end else begin
      taken_q      <= taken_d;
      taken_addr_q <= taken_addr_d;
    end
  end

  // NOTE: the tables must come out of reset cold, so they are flop arrays with a full reset, not RAM.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < BTB_N; i++) begin
        btb_valid_q[i]  <= 1'b0;
        btb_tag_q[i]    <= '0;
        btb_target_q[i] <= 32'h0;
      end
      for (int i = 0; i < PHT_N; i++) begin
        pht_q[i] <= 2'b01;
      end
    end else begin
      if (m_ctl && Branch_resolved) begin
        btb_valid_q[m_btb_idx]  <= 1'b1;
        btb_tag_q[m_btb_idx]    <= m_tag;
        btb_target_q[m_btb_idx] <= Branch_resolved_addr;
      end
      if (m_is_branch) begin
        pht_q[m_pht_idx] <= pht_d;
      end
    end
  end

  assign Taken      = taken_q;
  assign Taken_addr = taken_addr_q;

`ifdef BP_TRACE_EN
  always @(posedge CLK) begin
    $display("[bp] fetch pc=%08h instr=%08h pred_taken=%0b target=%08h",
             Instr_addr_input, Instr_input, taken_d, taken_addr_d);
    if (m_ctl) begin
      $display("[bp] mem   pc=%08h %s", Branch_addr, Branch_resolved ? "taken" : "not taken");
    end
  end
`else
`endif

endmodule

// File: tb/tb_bimodal_btb_predictor.sv
// Directed bench for bimodal_btb_predictor: a driver queues expected predictions, a monitor
// pops and compares them one cycle after each fetch is presented.
module tb_bimodal_btb_predictor;
  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        FLUSH = 1'b0;
  logic [31:0] Instr_input = 32'h0;
  logic [31:0] Instr_addr_input = 32'h0;
  logic [31:0] Branch_instr = 32'h0;
  logic [31:0] Branch_addr = 32'h0;
  logic        Branch_resolved = 1'b0;
  logic [31:0] Branch_resolved_addr = 32'h0;
  logic        Taken;
  logic [31:0] Taken_addr;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam logic [31:0] BEQ    = 32'h1000_0004;
  localparam logic [31:0] J      = 32'h0810_0040;
  localparam logic [31:0] JR     = 32'h03E0_0008;
  localparam logic [31:0] ADD    = 32'h0000_0020;
  localparam logic [31:0] MOVZ   = 32'h0000_000A;
  localparam logic [31:0] BGEZAL = 32'h0411_0000;
  localparam logic [31:0] BLEZ   = 32'h1800_0000;

  typedef struct {
    logic        taken;
    logic [31:0] addr;
    string       name;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic exp_valid = 1'b0;
  logic out_valid = 1'b0;

  bimodal_btb_predictor dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .FLUSH               (FLUSH),
    .Instr_input         (Instr_input),
    .Instr_addr_input    (Instr_addr_input),
    .Branch_instr        (Branch_instr),
    .Branch_addr         (Branch_addr),
    .Branch_resolved     (Branch_resolved),
    .Branch_resolved_addr(Branch_resolved_addr),
    .Taken               (Taken),
    .Taken_addr          (Taken_addr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic act_t, input logic [31:0] act_a,
                       input logic exp_tk, input logic [31:0] exp_a);
    n_cmp++;
    if (act_t !== exp_tk || act_a !== exp_a) begin
      n_bad++;
      $display("FAIL %s: got Taken=%0b Taken_addr=%08h, expected Taken=%0b Taken_addr=%08h",
               name, act_t, act_a, exp_tk, exp_a);
    end
  endtask

  // Monitor: the output register has one cycle of latency.
  always @(posedge CLK) out_valid <= exp_valid;

  always @(negedge CLK) begin
    exp_t e;
    if (out_valid) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL scoreboard_empty: output presented with no expectation queued");
      end else begin
        e = sb_q.pop_front();
        check(e.name, Taken, Taken_addr, e.taken, e.addr);
      end
    end
  end

  task automatic mem(input logic [31:0] instr, input logic [31:0] pc,
                     input logic res, input logic [31:0] res_addr);
    Branch_instr         = instr;
    Branch_addr          = pc;
    Branch_resolved      = res;
    Branch_resolved_addr = res_addr;
  endtask

  task automatic fetch(input string name, input logic [31:0] instr, input logic [31:0] pc,
                       input logic exp_tk, input logic [31:0] exp_a);
    exp_t e;
    Instr_input      = instr;
    Instr_addr_input = pc;
    e.taken = exp_tk;
    e.addr  = exp_a;
    e.name  = name;
    sb_q.push_back(e);
    exp_valid = 1'b1;
    @(negedge CLK);
    mem(NOP, 32'h0, 1'b0, 32'h0);
    FLUSH = 1'b0;
  endtask

  task automatic train(input logic [31:0] instr, input logic [31:0] pc,
                       input logic res, input logic [31:0] res_addr);
    mem(instr, pc, res, res_addr);
    fetch("train_slot_nop", NOP, 32'h0040_0000, 1'b0, 32'h0);
  endtask

  initial begin
    int waited;
    @(negedge CLK);
    @(negedge CLK);
    check("reset_state", Taken, Taken_addr, 1'b0, 32'h0);
    RESET = 1'b0;

    fetch("cold_beq", BEQ, 32'h0040_0010, 1'b0, 32'h0);

    mem(J, 32'h0040_0020, 1'b1, 32'h0040_0100);
    fetch("nop_while_train_j", NOP, 32'h0040_0000, 1'b0, 32'h0);
    fetch("j_hit", J, 32'h0040_0020, 1'b1, 32'h0040_0100);
    fetch("alias_j", J, 32'h0040_0120, 1'b0, 32'h0);
    fetch("non_ctl_at_j_pc", ADD, 32'h0040_0020, 1'b0, 32'h0);

    // BEQ @0x400040: PHT counter starts at 01.
    mem(BEQ, 32'h0040_0040, 1'b1, 32'h0040_0080);
    fetch("no_bypass_same_cycle", BEQ, 32'h0040_0040, 1'b0, 32'h0);
    fetch("beq_ctr2", BEQ, 32'h0040_0040, 1'b1, 32'h0040_0080);
    train(BEQ, 32'h0040_0040, 1'b0, 32'h0040_0044);
    fetch("beq_ctr1", BEQ, 32'h0040_0040, 1'b0, 32'h0);
    train(BEQ, 32'h0040_0040, 1'b0, 32'h0040_0044);
    fetch("beq_ctr0", BEQ, 32'h0040_0040, 1'b0, 32'h0);
    train(BEQ, 32'h0040_0040, 1'b0, 32'h0040_0044);
    train(BEQ, 32'h0040_0040, 1'b1, 32'h0040_0080);
    fetch("beq_sat_low", BEQ, 32'h0040_0040, 1'b0, 32'h0);
    train(BEQ, 32'h0040_0040, 1'b1, 32'h0040_0080);
    train(BEQ, 32'h0040_0040, 1'b1, 32'h0040_0080);
    train(BEQ, 32'h0040_0040, 1'b1, 32'h0040_0080);
    train(BEQ, 32'h0040_0040, 1'b0, 32'h0040_0044);
    fetch("beq_sat_high", BEQ, 32'h0040_0040, 1'b1, 32'h0040_0080);
    train(BEQ, 32'h0040_0040, 1'b0, 32'h0040_0044);
    fetch("beq_ctr1_again", BEQ, 32'h0040_0040, 1'b0, 32'h0);

    train(JR, 32'h0040_0200, 1'b1, 32'h0040_0300);
    fetch("jr_hit", JR, 32'h0040_0200, 1'b1, 32'h0040_0300);
    train(MOVZ, 32'h0040_0708, 1'b1, 32'h0040_0800);
    fetch("non_ctl_mem_no_write", JR, 32'h0040_0708, 1'b0, 32'h0);
    train(BGEZAL, 32'h0040_070C, 1'b1, 32'h0040_0900);
    fetch("bgezal_hit", BGEZAL, 32'h0040_070C, 1'b1, 32'h0040_0900);

    mem(BLEZ, 32'h0040_0A10, 1'b1, 32'h0040_0B00);
    FLUSH = 1'b1;
    fetch("flush", J, 32'h0040_0020, 1'b0, 32'h0);
    fetch("after_flush", J, 32'h0040_0020, 1'b1, 32'h0040_0100);
    fetch("trained_during_flush", BLEZ, 32'h0040_0A10, 1'b1, 32'h0040_0B00);

    fetch("pre_reset_j", J, 32'h0040_0020, 1'b1, 32'h0040_0100);
    exp_valid        = 1'b0;
    Instr_input      = NOP;
    Instr_addr_input = 32'h0;
    #2 RESET = 1'b1;
    #1 check("async_reset", Taken, Taken_addr, 1'b0, 32'h0);
    @(negedge CLK);
    RESET = 1'b0;
    fetch("j_after_reset", J, 32'h0040_0020, 1'b0, 32'h0);

    exp_valid = 1'b0;
    waited = 0;
    while (sb_q.size() != 0 && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d expectations left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
